// File: rtl/rng_pkg.sv
// Shared state encoding, default tuning constants and sizing helper
// for the RNG harvester and its output FIFO.
package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_ALARM  = 2'd3
  } rng_state_e;

  localparam int WIDTH_DEF      = 32;
  localparam int DECIM_DEF      = 4;
  localparam int WARMUP_DEF     = 64;
  localparam int RCT_CUTOFF_DEF = 4;
  localparam int APT_WINDOW_DEF = 64;
  localparam int APT_CUTOFF_DEF = 8;
  localparam int DEPTH_DEF      = 4;

  // Bits needed for a counter that must hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rng_fifo.sv
// First-word-fall-through FIFO for conditioned words. A push into a full
// FIFO is dropped unless a pop happens in the same cycle; flush empties it.
module rng_fifo
  import rng_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is reset only because the head word is visible on rdata
  // straight out of reset; larger memories should be left unreset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/rng_harvester.sv
// RNG consumer: continuous repetition-count and adaptive-proportion health
// tests, XOR-fold conditioning and a buffered valid/ready output with alarm.
module rng_harvester
  import rng_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DECIM      = DECIM_DEF,
  parameter int WARMUP     = WARMUP_DEF,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int APT_WINDOW = APT_WINDOW_DEF,
  parameter int APT_CUTOFF = APT_CUTOFF_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [WIDTH-1:0]       rng_word_i,
  input  logic                   rng_valid_i,
  input  logic                   clr_alarm_i,
  output logic [WIDTH-1:0]       rnd_data_o,
  output logic                   rnd_valid_o,
  input  logic                   rnd_ready_i,
  output logic                   alarm_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [1:0]             state_o
);

  localparam int WU_W   = cnt_width(WARMUP);
  localparam int RCT_W  = cnt_width(RCT_CUTOFF);
  localparam int APT_W  = cnt_width(APT_WINDOW);
  localparam int FOLD_W = cnt_width(DECIM);

  localparam logic [WU_W-1:0]   WU_LAST   = WU_W'(WARMUP - 1);
  localparam logic [RCT_W-1:0]  RCT_LIMIT = RCT_W'(RCT_CUTOFF);
  localparam logic [APT_W-1:0]  APT_LEN   = APT_W'(APT_WINDOW);
  localparam logic [APT_W-1:0]  APT_LIMIT = APT_W'(APT_CUTOFF);
  localparam logic [FOLD_W-1:0] FOLD_LAST = FOLD_W'(DECIM - 1);

  rng_state_e        state_q, state_d;
  logic [WU_W-1:0]   wu_cnt;
  logic [WIDTH-1:0]  rct_prev;
  logic [RCT_W-1:0]  rct_cnt, rct_cnt_nx;
  logic [WIDTH-1:0]  apt_ref;
  logic [APT_W-1:0]  apt_idx, apt_match, apt_match_nx;
  logic              apt_new;
  logic [WIDTH-1:0]  acc;
  logic [FOLD_W-1:0] fold_cnt;
  logic              testing, sample, fail, fold_done;
  logic              flush, push, pop, fifo_full, fifo_empty;

  assign testing = (state_q == ST_WARMUP) || (state_q == ST_RUN);
  assign sample  = rng_valid_i && testing;

  // A zero count means "cleared": the next sample starts a fresh run/window.
  assign rct_cnt_nx   = (rct_cnt != '0 && rng_word_i == rct_prev) ? rct_cnt + 1'b1 : RCT_W'(1);
  assign apt_new      = (apt_idx == '0) || (apt_idx == APT_LEN);
  assign apt_match_nx = apt_new ? APT_W'(1) : apt_match + APT_W'(rng_word_i == apt_ref);
  assign fail         = sample && (rct_cnt_nx == RCT_LIMIT || apt_match_nx == APT_LIMIT);

  // Health state and warm-up count only live while testing, so they are
  // already clean whenever WARMUP is (re)entered.
  always_ff @(posedge clk) begin
    if (!rst || !testing) begin
      wu_cnt    <= '0;
      rct_prev  <= '0;
      rct_cnt   <= '0;
      apt_ref   <= '0;
      apt_idx   <= '0;
      apt_match <= '0;
    end else if (sample) begin
      rct_prev  <= rng_word_i;
      rct_cnt   <= rct_cnt_nx;
      apt_idx   <= apt_new ? APT_W'(1) : apt_idx + 1'b1;
      apt_match <= apt_match_nx;
      if (apt_new)                wu_cnt <= wu_cnt;
      if (apt_new)                apt_ref <= rng_word_i;
      if (state_q == ST_WARMUP)   wu_cnt <= wu_cnt + 1'b1;
    end
  end

  assign fold_done = sample && (state_q == ST_RUN) && (fold_cnt == FOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst || state_q != ST_RUN) begin
      acc      <= '0;
      fold_cnt <= '0;
    end else if (sample) begin
      if (fold_cnt == FOLD_LAST) begin
        acc      <= '0;
        fold_cnt <= '0;
      end else begin
        acc      <= acc ^ rng_word_i;
        fold_cnt <= fold_cnt + 1'b1;
      end
    end
  end

  // NOTE: the state register uses non-blocking assignment so every process
  // sampling state_q on this edge sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: state_d is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (en_i) state_d = ST_WARMUP;
      ST_WARMUP: begin
        if (fail)                               state_d = ST_ALARM;
        else if (!en_i)                         state_d = ST_IDLE;
        else if (sample && wu_cnt == WU_LAST)   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fail)       state_d = ST_ALARM;
        else if (!en_i) state_d = ST_IDLE;
      end
      ST_ALARM:  if (clr_alarm_i) state_d = en_i ? ST_WARMUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Flush on leaving WARMUP/RUN so level_o is already 0 in the first
  // IDLE/ALARM cycle; a fold completing on that same sample is discarded.
  assign flush = testing && (state_d == ST_IDLE || state_d == ST_ALARM);
  assign pop   = rnd_valid_o && rnd_ready_i;
  assign push  = fold_done && !flush && (!fifo_full || pop);

  rng_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (acc ^ rng_word_i),
    .rdata (rnd_data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  assign rnd_valid_o = (state_q == ST_RUN) && !fifo_empty;
  assign alarm_o     = (state_q == ST_ALARM);
  assign state_o     = state_q;

endmodule

// File: doc/rng_harvester.md
Name: rng_harvester

Overview:
- Consumer side of the on-chip RNG. Samples raw words from the cellular-automaton generator and runs continuous health tests on them: a repetition count test (RCT) and an adaptive proportion test (APT), in the style of SP800-90B.
- XOR-folds DECIM raw samples into one conditioned word and buffers conditioned words in a small FIFO.
- Serves the crypto datapath over a valid/ready handshake. Raises a sticky alarm on any health failure.

Parameters:
- WIDTH, 32, raw and conditioned word width.
- DECIM, 4, raw samples XOR-folded per output word (≥1).
- WARMUP, 64, valid samples discarded after start or restart (≥1).
- RCT_CUTOFF, 4, consecutive identical samples that trigger failure (≥2).
- APT_WINDOW, 64, APT window length in samples.
- APT_CUTOFF, 8, matches of the window reference that trigger failure (≥2, ≤APT_WINDOW).
- DEPTH, 4, output FIFO entries (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- en_i  in  1  harvester enable.
- rng_word_i  in  WIDTH  raw generator word.
- rng_valid_i  in  1  rng_word_i is a fresh sample this cycle.
- clr_alarm_i  in  1  clears the alarm (level, sampled each cycle).
- rnd_data_o  out  WIDTH  conditioned word at the FIFO head.
- rnd_valid_o  out  1  FIFO non-empty and state RUN.
- rnd_ready_i  in  1  consumer accepts the head word.
- alarm_o  out  1  health test failed; sticky.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- state_o  out  2  FSM state: IDLE=0, WARMUP=1, RUN=2, ALARM=3.

Behaviour:
- Reset (rst==0 at posedge) forces:
  - state IDLE; all counters, RCT/APT state, fold accumulator and FIFO cleared.
  - rnd_data_o=0, rnd_valid_o=0, alarm_o=0, level_o=0.
- A sample is a cycle with rng_valid_i=1 in WARMUP or RUN. Samples in IDLE and ALARM are ignored.
- FSM:
  - IDLE: en_i=1 → WARMUP; the warm-up count and health-test state are cleared on entry.
  - WARMUP: health tests run on every sample; no fold. After WARMUP samples → RUN.
  - RUN: tests run and samples fold.
  - Any RCT/APT failure in WARMUP or RUN → ALARM in the cycle after the failing sample.
  - en_i=0 in WARMUP or RUN → IDLE next cycle; FIFO and accumulator flushed.
  - ALARM: FIFO flushed on entry; alarm_o=1. en_i is ignored. clr_alarm_i=1 → WARMUP if en_i=1, else IDLE. Only way out of ALARM besides reset.
  - Failure and en_i=0 in the same cycle: ALARM wins.
- RCT:
  - Tracks prev sample and run count.
  - First sample after clear: count=1.
  - Sample equal to prev: count++; otherwise count=1.
  - count reaching RCT_CUTOFF = failure.
- APT:
  - First sample of a window becomes ref; match=1, idx=1.
  - Each later sample in the window: idx++; if equal to ref, match++.
  - match reaching APT_CUTOFF = failure.
  - After APT_WINDOW samples, the next sample starts a new window.
- Fold:
  - acc ^= sample per RUN sample.
  - On the DECIM-th sample, acc^sample is pushed the next cycle (latency 1 sample→push) and acc is cleared.
  - If the FIFO is full at push, the word is discarded silently.
  - Health tests still see every sample regardless of FIFO state.
- FIFO:
  - Output is first-word-fall-through: rnd_data_o is valid in the same cycle as rnd_valid_o.
  - Pop when rnd_valid_o && rnd_ready_i.
  - Simultaneous push and pop when full is allowed: level unchanged, no drop.
  - rnd_data_o holds the head word even when rnd_valid_o=0; it is not required to be 0 after a flush.
- level_o reports true occupancy, including entries hidden when state≠RUN. It is 0 after any flush.

Decomposition:
- Package rng_pkg:
  - state enum rng_state_e {IDLE, WARMUP, RUN, ALARM}.
  - default cutoff/window constants.
  - a function computing the counter width from a parameter.
- One sub-module, rng_fifo: parameterised WIDTH/DEPTH synchronous FIFO with flush, push, pop, full, empty and level.
- Health tests, fold and FSM stay in rng_harvester.

Test Plan:
- Reset/idle: rst low 2 cycles, en_i=0, valid samples fed → state_o=0, rnd_valid_o=0, alarm_o=0, level_o=0 throughout.
- Warm-up and fold: WARMUP=64, DECIM=4, en_i=1, distinct samples every cycle.
  - state_o=2 after the 64th sample.
  - After samples 65..68 = 1,2,4,8, rnd_data_o=0xF and rnd_valid_o=1 one cycle after sample 68.
- RCT: in RUN, feed 0xDEADBEEF 4 times in a row → state_o=3 and alarm_o=1 one cycle after the 4th. FIFO flushed, level_o=0.
- APT: 64-sample window with ref 0xA5A5A5A5 repeated non-consecutively 8 times, interleaved with distinct values → alarm on the 8th match. With only 7 matches, no alarm; the window rolls over and the test restarts.
- Backpressure: rnd_ready_i=0 until level_o=4 → further folded words dropped, level_o stays 4. Then rnd_ready_i=1 → words drained in push order.
- Alarm clear and disable: in ALARM, drop en_i → stays ALARM. clr_alarm_i=1 with en_i=0 → IDLE. Repeat with en_i=1 → WARMUP, with a fresh 64-sample warm-up before any output.
